// File: rtl/param_datamemory.sv
// param_datamemory: parametrised single-port data memory with per-byte write
// enables, a registered one-cycle read/write result path and a reset-time
// clear sequence that zeroes every word before the block reports ready.
module param_datamemory #(
  parameter int unsigned WIDTH      = 32,
  parameter int unsigned DEPTH      = 128,
  parameter int unsigned ADDR_WIDTH = 7
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    req,
  input  logic                    writeEnable,
  input  logic [WIDTH/8-1:0]      byteEnable,
  input  logic [ADDR_WIDTH-1:0]   address,
  input  logic [WIDTH-1:0]        dataIn,
  output logic                    ready,
  output logic [WIDTH-1:0]        dataOut,
  output logic                    dataValid,
  output logic                    addrError
);

  localparam int unsigned BYTES = WIDTH / 8;

  // Elaboration-time parameter sanity checks.
  if ((WIDTH % 8) != 0 || WIDTH == 0) begin : g_width_check
    $error("param_datamemory: WIDTH must be a non-zero multiple of 8");
  end
  if (DEPTH == 0 || (64'(1) << ADDR_WIDTH) < 64'(DEPTH)) begin : g_depth_check
    $error("param_datamemory: 2**ADDR_WIDTH must cover DEPTH");
  end

  typedef enum logic {
    CLEAR = 1'b0,
    RUN   = 1'b1
  } state_t;

  state_t                  state;
  state_t                  next_state;
  logic [ADDR_WIDTH-1:0]   counter;
  logic                    clear_last;
  logic                    accept;
  logic                    in_range;
  logic                    do_write;
  logic [WIDTH-1:0]        rd_word;
  logic [WIDTH-1:0]        merged;
  logic [WIDTH-1:0]        mem [DEPTH];

  assign clear_last = (32'(counter) == DEPTH - 1);
  assign in_range   = (32'(address) < DEPTH);
  assign accept     = req && ready;
  assign do_write   = accept && writeEnable && in_range;

  // State register; reset always restarts the clear sequence.
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= CLEAR;
    end else begin
      state <= next_state;
    end
  end

  // Next-state and handshake: ready only once every word has been zeroed.
  always_comb begin
    next_state = state;
    ready      = 1'b0;
    unique case (state)
      CLEAR: begin
        if (clear_last) begin
          next_state = RUN;
        end
      end
      RUN: begin
        ready = 1'b1;
      end
      default: begin
        next_state = CLEAR;
      end
    endcase
  end

  // Clear-sequence word counter.
  always_ff @(posedge clk) begin
    if (reset) begin
      counter <= '0;
    end else if (state == CLEAR) begin
      counter <= clear_last ? '0 : counter + 1'b1;
    end
  end

  // Write-first merge: lanes with byteEnable set come from dataIn, the rest
  // from the current word; reads simply see the unmerged word.
  always_comb begin
    rd_word = mem[address];
    merged  = rd_word;
    for (int unsigned b = 0; b < BYTES; b++) begin
      if (byteEnable[b]) begin
        merged[8*b +: 8] = dataIn[8*b +: 8];
      end
    end
  end

  // Storage array: zeroed word-by-word during CLEAR, merged writes in RUN.
  always_ff @(posedge clk) begin
    if (!reset) begin
      if (state == CLEAR) begin
        mem[counter] <= '0;
      end else if (do_write) begin
        mem[address] <= merged;
      end
    end
  end

  // Registered result path: one dataValid per accepted access, data held
  // between accesses, out-of-range accesses return zero with addrError.
  always_ff @(posedge clk) begin
    if (reset) begin
      dataValid <= 1'b0;
      addrError <= 1'b0;
      dataOut   <= '0;
    end else if (accept) begin
      dataValid <= 1'b1;
      addrError <= !in_range;
      if (!in_range) begin
        dataOut <= '0;
      end else if (writeEnable) begin
        dataOut <= merged;
      end else begin
        dataOut <= rd_word;
      end
    end else begin
      dataValid <= 1'b0;
      addrError <= 1'b0;
    end
  end

endmodule

// File: tb/tb_param_datamemory.sv
// Scoreboard bench for param_datamemory: stimulus pushes expected results
// computed from a word-array model, a monitor pops on every dataValid.
module tb_param_datamemory;

  localparam int W  = 32;
  localparam int D  = 100;
  localparam int AW = 7;
  localparam int NB = W / 8;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          req = 1'b0;
  logic          we = 1'b0;
  logic [NB-1:0] be = '0;
  logic [AW-1:0] addr = '0;
  logic [W-1:0]  din = '0;
  logic          ready;
  logic [W-1:0]  dout;
  logic          dvalid;
  logic          aerr;

  param_datamemory #(
    .WIDTH(W),
    .DEPTH(D),
    .ADDR_WIDTH(AW)
  ) dut (
    .clk(clk),
    .reset(reset),
    .req(req),
    .writeEnable(we),
    .byteEnable(be),
    .address(addr),
    .dataIn(din),
    .ready(ready),
    .dataOut(dout),
    .dataValid(dvalid),
    .addrError(aerr)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [W-1:0] data;
    logic         err;
    string        tag;
  } exp_t;

  exp_t         sb[$];
  int           total = 0;
  int           bad = 0;
  logic [W-1:0] model [D];
  logic [W-1:0] hold_exp = '0;
  exp_t         mon_e;

  function automatic void check(string tag, logic [W-1:0] act, logic [W-1:0] want);
    total++;
    if (act !== want) begin
      bad++;
      $display("FAIL %s: got %h want %h", tag, act, want);
    end
  endfunction

  function automatic logic [W-1:0] lane_mask(logic [NB-1:0] b);
    logic [W-1:0] m;
    for (int i = 0; i < W; i++) m[i] = b[i/8];
    return m;
  endfunction

  // Monitor: posedge tracks reset (drops in-flight results, zeroes dataOut),
  // negedge compares against the scoreboard or against the held value.
  always @(posedge clk or negedge clk) begin
    if (clk) begin
      if (reset) begin
        hold_exp <= '0;
        sb.delete();
      end
    end else begin
      if (dvalid === 1'b1) begin
        if (sb.size() == 0) begin
          total++;
          bad++;
          $display("FAIL unexpected_valid: got dataValid=1 dataOut=%h want no result", dout);
        end else begin
          mon_e = sb.pop_front();
          check({mon_e.tag, "_data"}, dout, mon_e.data);
          check({mon_e.tag, "_err"}, W'(aerr), W'(mon_e.err));
          hold_exp <= mon_e.data;
        end
      end else begin
        check("idle_valid", W'(dvalid), '0);
        check("idle_err", W'(aerr), '0);
        check("hold_data", dout, hold_exp);
      end
    end
  end

  task automatic access(input logic w, input logic [NB-1:0] b, input logic [AW-1:0] a,
                        input logic [W-1:0] d, input string tag);
    exp_t e;
    check({tag, "_ready"}, W'(ready), W'(1));
    req = 1'b1; we = w; be = b; addr = a; din = d;
    e.tag = tag;
    if (int'(a) >= D) begin
      e.data = '0;
      e.err  = 1'b1;
    end else begin
      if (w) model[a] = (model[a] & ~lane_mask(b)) | (d & lane_mask(b));
      e.data = model[a];
      e.err  = 1'b0;
    end
    sb.push_back(e);
    @(posedge clk); #1;
    req = 1'b0; we = 1'b0;
  endtask

  // Waits for ready with a cycle bound; optionally keeps requesting meanwhile.
  task automatic wait_ready(input string tag);
    int cyc = 0;
    int stray = 0;
    while (ready !== 1'b1 && cyc < 500) begin
      @(posedge clk); #1;
      cyc++;
      if (dvalid === 1'b1) stray++;
    end
    req = 1'b0;
    check({tag, "_clear_cycles"}, W'(cyc), W'(D));
    check({tag, "_stray_valid"}, W'(stray), '0);
    for (int i = 0; i < D; i++) model[i] = '0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    // Reset held for two edges; check reset state.
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("rst_ready", W'(ready), '0);
    check("rst_valid", W'(dvalid), '0);
    check("rst_err", W'(aerr), '0);
    check("rst_dout", dout, '0);
    reset = 1'b0;
    wait_ready("init");

    access(1'b0, '1, 7'd0,  '0, "rd0");
    access(1'b0, '1, 7'd50, '0, "rd50");
    access(1'b0, '1, 7'd99, '0, "rd99");

    access(1'b1, 4'b1111, 7'd1, 32'hDEADBEEF, "wr_full");
    access(1'b0, 4'b1111, 7'd1, 32'h0,        "rd_full");
    access(1'b1, 4'b0010, 7'd1, 32'h11225533, "wr_lane");
    access(1'b0, 4'b0000, 7'd1, 32'h0,        "rd_lane");
    access(1'b0, 4'b1111, 7'd1, 32'hFFFFFFFF, "rd_nowrite");
    access(1'b1, 4'b1111, 7'd127, 32'h12345678, "wr_oor");
    access(1'b0, 4'b1111, 7'd127, 32'h0, "rd_oor");
    access(1'b0, 4'b1111, 7'd99,  32'h0, "rd_last");
    access(1'b1, 4'b0000, 7'd2, 32'hA5A5A5A5, "wr_nobe");
    access(1'b0, 4'b1111, 7'd2, 32'h0, "rd_nobe");
    access(1'b1, 4'b1001, 7'd3, 32'h87654321, "wr_b2b");
    access(1'b0, 4'b0000, 7'd3, 32'h0, "rd_b2b");

    // Randomised traffic, mostly in range, with occasional idle cycles.
    for (int n = 0; n < 400; n++) begin
      logic [AW-1:0] a;
      a = ($urandom_range(0, 7) == 0) ? AW'($urandom_range(D, 127)) : AW'($urandom_range(0, D - 1));
      if (($urandom & 32'h3) == 0) begin
        @(posedge clk); #1;
      end
      access(1'($urandom), NB'($urandom), a, $urandom, "rand");
    end

    // Reset in the cycle after a read request.
    access(1'b1, 4'b1111, 7'd7, 32'hCAFEF00D, "wr7");
    access(1'b0, 4'b1111, 7'd7, 32'h0, "rd7");
    reset = 1'b1;
    @(posedge clk); #1;
    check("midrst_valid", W'(dvalid), '0);
    check("midrst_ready", W'(ready), '0);
    reset = 1'b0;
    req = 1'b1; we = 1'b1; be = '1; addr = 7'd7; din = 32'h55555555;
    wait_ready("midrst");
    we = 1'b0;
    access(1'b0, 4'b1111, 7'd7, 32'h0, "rd7_after_rst");

    repeat (3) @(posedge clk);
    #1;
    check("sb_drained", W'(sb.size()), '0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
